// File: rtl/debouncer.sv
// Multi-bit level debouncer: one shared free-running sample tick, and a
// saturating run-length counter per bit that must see PULSE_CNT_MAX highs in a row.
module debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal
);

    localparam int SW = $clog2(SAMPLE_CNT_MAX);
    localparam int CW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [CW-1:0] PULSE_FULL  = CW'(PULSE_CNT_MAX);

    logic [SW-1:0]            sample_cnt_q;
    logic [SW-1:0]            sample_cnt_d;
    logic                     tick_s;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_d;
    logic [WIDTH-1:0]         out_q;
    logic [WIDTH-1:0]         out_d;

    // Shared sample-tick generator, free-running independent of the inputs.
    always_comb begin
        tick_s = (sample_cnt_q == SAMPLE_LAST);
        if (tick_s) begin
            sample_cnt_d = {SW{1'b0}};
        end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
        end
    end

    // Per-bit run-length counters; the output is decoded from the next count
    // and registered so it changes on the same edge that the count reaches full.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick_s) begin
                if (glitchy_signal[i]) begin
                    if (cnt_q[i] < PULSE_FULL) begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end else begin
                        cnt_d[i] = PULSE_FULL;
                    end
                end else begin
                    cnt_d[i] = {CW{1'b0}};
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            out_d[i] = (cnt_d[i] == PULSE_FULL);
        end
    end

    // State registers with asynchronous clear of every partial count and the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= {SW{1'b0}};
            cnt_q        <= '0;
            out_q        <= {WIDTH{1'b0}};
        end else begin
            sample_cnt_q <= sample_cnt_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
        end
    end

    assign debounced_signal = out_q;

endmodule
